apb_const_regfile: RTL

Parametrised APB3/APB4 slave holding a bank of read-only constant words followed by a bank of byte-strobed read/write scratch registers. It serves peripheral reads and writes with a programmable number of wait states. It reports address, alignment and write-protection faults on pslverr. It sits on the peripheral bus behind the APB bridge and replaces the fixed four-word constant reader. The constant bank still defaults to the pi/e words at indices 0..3.

---
 rtl/apb_const_pkg.sv | 22 ++
 rtl/apb_rw_bank.sv | 52 +++++
 rtl/apb_const_regfile.sv | 130 +++++++++++++
 3 files changed

// File: rtl/apb_const_pkg.sv
// Shared types and constants for the APB constant/scratch register file.
package apb_const_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Default constant words: pi and e fractional expansions.
  localparam logic [31:0] PI_HI = 32'h3243F6A8;
  localparam logic [31:0] PI_LO = 32'h885A308D;
  localparam logic [31:0] E_HI  = 32'h2B7E1516;
  localparam logic [31:0] E_LO  = 32'h28AED2A6;

  // Index 0 sits in the most significant word of the concatenation.
  localparam logic [127:0] RO_DEFAULT = {PI_HI, PI_LO, E_HI, E_LO};

  // Width of the wait-state counter.
  localparam int WS_W = 4;

endpackage

// File: rtl/apb_rw_bank.sv
// Byte-strobed scratch register bank with async reset and a combinational read port.
module apb_rw_bank
  import apb_const_pkg::*;
#(
  parameter int                N_RW     = 4,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RW_RESET = '0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  we,
  input  logic [7:0]            widx,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic [7:0]            ridx,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [N_RW];

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [DATA_W/8-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  // Storage update: reset to RW_RESET, otherwise merge strobed bytes into the addressed word.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < N_RW; i++) mem[i] <= RW_RESET;
    end else begin
      for (int i = 0; i < N_RW; i++) begin
        if (we && (widx == 8'(i))) mem[i] <= strb_merge(mem[i], wdata, wstrb);
      end
    end
  end

  // Read mux; an index outside the bank reads as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_RW; i++) begin
      if (ridx == 8'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/apb_const_regfile.sv
// APB slave: read-only constant words followed by byte-strobed scratch words,
// with programmable wait states and fault reporting on pslverr.
module apb_const_regfile
  import apb_const_pkg::*;
#(
  parameter int                     ADDR_W      = 32,
  parameter int                     DATA_W      = 32,
  parameter int                     N_RO        = 4,
  parameter int                     N_RW        = 4,
  parameter int                     WAIT_STATES = 0,
  parameter logic [N_RO*DATA_W-1:0] RO_INIT     = RO_DEFAULT,
  parameter logic [DATA_W-1:0]      RW_RESET    = '0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_W-1:0]     prdata
);

  localparam int N_TOT = N_RO + N_RW;

  state_t            state_q, state_d;
  logic [WS_W-1:0]   cnt_q, cnt_d;
  logic              pready_d, pslverr_d;
  logic [DATA_W-1:0] prdata_d;
  logic              we;

  logic [7:0]        idx;
  logic [7:0]        rw_off;
  logic              ro_hit, misalign, hi_bad, range_bad, err;
  logic [DATA_W-1:0] ro_word, rw_word, rd_word;

  // Address decode and fault classification.
  assign idx       = paddr[9:2];
  assign rw_off    = idx - 8'(N_RO);
  assign misalign  = |paddr[1:0];
  assign hi_bad    = |paddr[ADDR_W-1:10];
  assign range_bad = {24'd0, idx} >= 32'(N_TOT);
  assign ro_hit    = {24'd0, idx} < 32'(N_RO);
  assign err       = misalign | hi_bad | range_bad | (pwrite & ro_hit);
  assign rd_word   = ro_hit ? ro_word : rw_word;

  // Constant-word mux; index 0 is the top word of RO_INIT.
  always_comb begin
    ro_word = '0;
    for (int i = 0; i < N_RO; i++) begin
      if (idx == 8'(i)) ro_word = RO_INIT[(N_RO-1-i)*DATA_W +: DATA_W];
    end
  end

  apb_rw_bank #(
    .N_RW     (N_RW),
    .DATA_W   (DATA_W),
    .RW_RESET (RW_RESET)
  ) u_rw_bank (
    .pclk   (pclk),
    .preset (preset),
    .we     (we),
    .widx   (rw_off),
    .wdata  (pwdata),
    .wstrb  (pstrb),
    .ridx   (rw_off),
    .rdata  (rw_word)
  );

  // Next-state and response logic; the access executes once the wait count is exhausted.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q < WS_W'(WAIT_STATES)) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = err;
            if (!err && !pwrite) prdata_d = rd_word;
            we = !err && pwrite;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pslverr_d = 1'b1;
      end
    endcase
  end

  // State, wait counter and registered bus outputs.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pready  <= pready_d;
      pslverr <= pslverr_d;
      prdata  <= prdata_d;
    end
  end

endmodule
